// File: rtl/dp_sink_pkg.sv
// rtl/dp_sink_pkg.sv - DPCD link-training sink constants, command codes and FSM states
package dp_sink_pkg;

   localparam logic [19:0] ADDR_DPCD_REV       = 20'h00000;
   localparam logic [19:0] ADDR_MAX_LINK_RATE  = 20'h00001;
   localparam logic [19:0] ADDR_MAX_LANE_CNT   = 20'h00002;
   localparam logic [19:0] ADDR_LINK_BW_SET    = 20'h00100;
   localparam logic [19:0] ADDR_LANE_COUNT_SET = 20'h00101;
   localparam logic [19:0] ADDR_TPS_SET        = 20'h00102;
   localparam logic [19:0] ADDR_LANE0_SET      = 20'h00103;
   localparam logic [19:0] ADDR_LANE1_SET      = 20'h00104;
   localparam logic [19:0] ADDR_LANE2_SET      = 20'h00105;
   localparam logic [19:0] ADDR_LANE3_SET      = 20'h00106;
   localparam logic [19:0] ADDR_LANE01_STATUS  = 20'h00202;
   localparam logic [19:0] ADDR_LANE23_STATUS  = 20'h00203;
   localparam logic [19:0] ADDR_ALIGN_STATUS   = 20'h00204;
   localparam logic [19:0] ADDR_ADJ_LANE01     = 20'h00206;
   localparam logic [19:0] ADDR_ADJ_LANE23     = 20'h00207;

   localparam logic [1:0] CMD_WRITE = 2'b00;
   localparam logic [1:0] CMD_READ  = 2'b01;

   localparam int STAT_CR   = 0;
   localparam int STAT_EQ   = 1;
   localparam int STAT_LOCK = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_DATA,
      ST_WAIT,
      ST_REPLY,
      ST_RD_DATA
   } state_t;

   function automatic logic is_cfg_addr(input logic [19:0] a);
      return (a >= ADDR_LINK_BW_SET) && (a <= ADDR_LANE3_SET);
   endfunction

endpackage

// File: rtl/dpcd_sink_regs.sv
// rtl/dpcd_sink_regs.sv - link-training DPCD register file, PHY status snapshot and read mux
module dpcd_sink_regs
   import dp_sink_pkg::*;
#(
   parameter logic [7:0] MAX_LINK_RATE = 8'h14,
   parameter logic [4:0] MAX_LANE_CNT  = 5'd4,
   parameter logic [7:0] DPCD_REV      = 8'h12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        snap_en,
   input  logic [3:0]  phy_cr_done,
   input  logic [3:0]  phy_eq_done,
   input  logic [3:0]  phy_symbol_lock,
   input  logic        phy_align_done,
   input  logic [7:0]  phy_adj_vtg,
   input  logic [7:0]  phy_adj_pre,
   input  logic        wr_en,
   input  logic [19:0] addr,
   input  logic [7:0]  wr_data,
   output logic [7:0]  rd_data,
   output logic [7:0]  sink_link_bw,
   output logic [4:0]  sink_lane_cnt,
   output logic [1:0]  sink_tps,
   output logic [31:0] sink_lane_set
);

   logic [7:0]  link_bw_q;
   logic [4:0]  lane_cnt_q;
   logic [7:0]  tps_q;
   logic [31:0] lane_set_q;
   logic [3:0]  snap_cr, snap_eq, snap_lock;
   logic        snap_align;
   logic [7:0]  snap_vtg, snap_pre;
   logic [3:0]  lane_on;
   logic [3:0][2:0] lane_stat;
   logic [3:0][3:0] lane_adj;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         link_bw_q  <= '0;
         lane_cnt_q <= '0;
         tps_q      <= '0;
         lane_set_q <= '0;
      end else if (wr_en) begin
         case (addr)
            ADDR_LINK_BW_SET:    link_bw_q         <= wr_data;
            ADDR_LANE_COUNT_SET: lane_cnt_q        <= wr_data[4:0];
            ADDR_TPS_SET:        tps_q             <= wr_data;
            ADDR_LANE0_SET:      lane_set_q[7:0]   <= wr_data;
            ADDR_LANE1_SET:      lane_set_q[15:8]  <= wr_data;
            ADDR_LANE2_SET:      lane_set_q[23:16] <= wr_data;
            ADDR_LANE3_SET:      lane_set_q[31:24] <= wr_data;
            default: ;
         endcase
      end
   end

   // Status is frozen at header accept so a read reflects one consistent instant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_cr    <= '0;
         snap_eq    <= '0;
         snap_lock  <= '0;
         snap_align <= 1'b0;
         snap_vtg   <= '0;
         snap_pre   <= '0;
      end else if (snap_en) begin
         snap_cr    <= phy_cr_done;
         snap_eq    <= phy_eq_done;
         snap_lock  <= phy_symbol_lock;
         snap_align <= phy_align_done;
         snap_vtg   <= phy_adj_vtg;
         snap_pre   <= phy_adj_pre;
      end
   end

   always_comb begin
      lane_on   = '0;
      lane_stat = '0;
      lane_adj  = '0;
      for (int i = 0; i < 4; i++) begin
         lane_on[i] = (5'(i) < lane_cnt_q);
         if (lane_on[i]) begin
            lane_stat[i][STAT_CR]   = snap_cr[i];
            lane_stat[i][STAT_EQ]   = snap_eq[i];
            lane_stat[i][STAT_LOCK] = snap_lock[i];
            lane_adj[i]             = {snap_pre[2*i +: 2], snap_vtg[2*i +: 2]};
         end
      end
   end

   always_comb begin
      rd_data = 8'h00;
      case (addr)
         ADDR_DPCD_REV:       rd_data = DPCD_REV;
         ADDR_MAX_LINK_RATE:  rd_data = MAX_LINK_RATE;
         ADDR_MAX_LANE_CNT:   rd_data = {3'b000, MAX_LANE_CNT};
         ADDR_LINK_BW_SET:    rd_data = link_bw_q;
         ADDR_LANE_COUNT_SET: rd_data = {3'b000, lane_cnt_q};
         ADDR_TPS_SET:        rd_data = tps_q;
         ADDR_LANE0_SET:      rd_data = lane_set_q[7:0];
         ADDR_LANE1_SET:      rd_data = lane_set_q[15:8];
         ADDR_LANE2_SET:      rd_data = lane_set_q[23:16];
         ADDR_LANE3_SET:      rd_data = lane_set_q[31:24];
         ADDR_LANE01_STATUS:  rd_data = {1'b0, lane_stat[1], 1'b0, lane_stat[0]};
         ADDR_LANE23_STATUS:  rd_data = {1'b0, lane_stat[3], 1'b0, lane_stat[2]};
         ADDR_ALIGN_STATUS:   rd_data = {7'b0, snap_align & (lane_cnt_q != 5'd0)};
         ADDR_ADJ_LANE01:     rd_data = {lane_adj[1], lane_adj[0]};
         ADDR_ADJ_LANE23:     rd_data = {lane_adj[3], lane_adj[2]};
         default:             rd_data = 8'h00;
      endcase
   end

   assign sink_link_bw  = link_bw_q;
   assign sink_lane_cnt = lane_cnt_q;
   assign sink_tps      = tps_q[1:0];
   assign sink_lane_set = lane_set_q;

endmodule

// File: rtl/dpcd_lt_sink.sv
// rtl/dpcd_lt_sink.sv - sink-side DPCD responder for native AUX link-training transactions
module dpcd_lt_sink
   import dp_sink_pkg::*;
#(
   parameter logic [7:0] MAX_LINK_RATE = 8'h14,
   parameter logic [4:0] MAX_LANE_CNT  = 5'd4,
   parameter logic [7:0] DPCD_REV      = 8'h12,
   parameter int         MAX_LEN       = 16,
   parameter int         RSP_LATENCY   = 2,
   parameter int         WR_TIMEOUT    = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_vld,
   output logic        req_ready,
   input  logic [1:0]  req_cmd,
   input  logic [19:0] req_address,
   input  logic [7:0]  req_len,
   input  logic [7:0]  req_data,
   input  logic        req_data_vld,
   output logic        rsp_ack,
   output logic        rsp_nack,
   output logic [7:0]  rsp_data,
   output logic        rsp_data_vld,
   input  logic [3:0]  phy_cr_done,
   input  logic [3:0]  phy_eq_done,
   input  logic [3:0]  phy_symbol_lock,
   input  logic        phy_align_done,
   input  logic [7:0]  phy_adj_vtg,
   input  logic [7:0]  phy_adj_pre,
   output logic [7:0]  sink_link_bw,
   output logic [4:0]  sink_lane_cnt,
   output logic [1:0]  sink_tps,
   output logic [31:0] sink_lane_set,
   output logic        sink_cfg_update
);

   // With a latency of one the reply follows the request directly, so WAIT is skipped.
   localparam state_t POST_REQ = (RSP_LATENCY > 1) ? ST_WAIT : ST_REPLY;

   state_t      state, state_nxt;
   logic        nack_q, is_rd_q, cfg_hit_q;
   logic [19:0] addr_q;
   logic [7:0]  len_q, byte_cnt;
   logic [15:0] tmr;
   logic        req_bad, wr_last, wr_timeout, wait_done, rd_last;
   logic        wr_en;
   logic [7:0]  rd_data;

   assign req_bad    = !(req_cmd == CMD_WRITE || req_cmd == CMD_READ) || (32'(req_len) >= MAX_LEN);
   assign wr_last    = req_data_vld && (byte_cnt == len_q);
   assign wr_timeout = !req_data_vld && (tmr == 16'(WR_TIMEOUT - 1));
   assign wait_done  = (tmr == 16'(RSP_LATENCY - 2));
   assign rd_last    = (byte_cnt == len_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:
            if (req_vld) state_nxt = (req_bad || req_cmd == CMD_READ) ? POST_REQ : ST_WR_DATA;
         ST_WR_DATA:
            if (wr_last)         state_nxt = POST_REQ;
            else if (wr_timeout) state_nxt = ST_IDLE;
         ST_WAIT:
            if (wait_done) state_nxt = ST_REPLY;
         ST_REPLY:
            state_nxt = (is_rd_q && !nack_q) ? ST_RD_DATA : ST_IDLE;
         ST_RD_DATA:
            if (rd_last) state_nxt = ST_IDLE;
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready       = (state == ST_IDLE);
      rsp_ack         = (state == ST_REPLY) && !nack_q;
      rsp_nack        = (state == ST_REPLY) && nack_q;
      sink_cfg_update = (state == ST_REPLY) && !nack_q && cfg_hit_q;
      rsp_data_vld    = (state == ST_RD_DATA);
      rsp_data        = (state == ST_RD_DATA) ? rd_data : 8'h00;
      wr_en           = (state == ST_WR_DATA) && req_data_vld;
   end

   // tmr counts idle write cycles in WR_DATA and latency cycles in WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nack_q    <= 1'b0;
         is_rd_q   <= 1'b0;
         cfg_hit_q <= 1'b0;
         addr_q    <= '0;
         len_q     <= '0;
         byte_cnt  <= '0;
         tmr       <= '0;
      end else begin
         case (state)
            ST_IDLE: if (req_vld) begin
               nack_q    <= req_bad;
               is_rd_q   <= (req_cmd == CMD_READ);
               cfg_hit_q <= 1'b0;
               addr_q    <= req_address;
               len_q     <= req_len;
               byte_cnt  <= '0;
               tmr       <= '0;
            end
            ST_WR_DATA: if (req_data_vld) begin
               addr_q   <= addr_q + 20'd1;
               byte_cnt <= byte_cnt + 8'd1;
               tmr      <= '0;
               if (is_cfg_addr(addr_q)) cfg_hit_q <= 1'b1;
            end else begin
               tmr <= tmr + 16'd1;
            end
            ST_WAIT:    tmr <= tmr + 16'd1;
            ST_REPLY:   byte_cnt <= '0;
            ST_RD_DATA: begin
               addr_q   <= addr_q + 20'd1;
               byte_cnt <= byte_cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

   dpcd_sink_regs #(
      .MAX_LINK_RATE (MAX_LINK_RATE),
      .MAX_LANE_CNT  (MAX_LANE_CNT),
      .DPCD_REV      (DPCD_REV)
   ) u_regs (
      .clk             (clk),
      .rst_n           (rst_n),
      .snap_en         (req_vld && req_ready),
      .phy_cr_done     (phy_cr_done),
      .phy_eq_done     (phy_eq_done),
      .phy_symbol_lock (phy_symbol_lock),
      .phy_align_done  (phy_align_done),
      .phy_adj_vtg     (phy_adj_vtg),
      .phy_adj_pre     (phy_adj_pre),
      .wr_en           (wr_en),
      .addr            (addr_q),
      .wr_data         (req_data),
      .rd_data         (rd_data),
      .sink_link_bw    (sink_link_bw),
      .sink_lane_cnt   (sink_lane_cnt),
      .sink_tps        (sink_tps),
      .sink_lane_set   (sink_lane_set)
   );

endmodule

// File: tb/tb_dpcd_lt_sink.sv
// tb/tb_dpcd_lt_sink.sv - scoreboard bench for the DPCD link-training sink responder
module tb_dpcd_lt_sink;

   localparam int RSP_LATENCY = 2;
   localparam int WR_TIMEOUT  = 64;
   localparam int K_ACK = 0, K_NACK = 1, K_DATA = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
      logic       cfg;
      int         cyc;
   } exp_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_vld = 1'b0, req_ready;
   logic [1:0]  req_cmd = 2'b00;
   logic [19:0] req_address = '0;
   logic [7:0]  req_len = '0, req_data = '0;
   logic        req_data_vld = 1'b0;
   logic        rsp_ack, rsp_nack, rsp_data_vld;
   logic [7:0]  rsp_data;
   logic [3:0]  phy_cr_done = '0, phy_eq_done = '0, phy_symbol_lock = '0;
   logic        phy_align_done = 1'b0;
   logic [7:0]  phy_adj_vtg = '0, phy_adj_pre = '0;
   logic [7:0]  sink_link_bw;
   logic [4:0]  sink_lane_cnt;
   logic [1:0]  sink_tps;
   logic [31:0] sink_lane_set;
   logic        sink_cfg_update;

   int   cyc = 0;
   int   n_pass = 0, n_total = 0;
   exp_t exp_q[$];
   logic [7:0] wbuf[$];
   logic [7:0] rexp[$];
   exp_t mon_e;
   int   mon_kind;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   dpcd_lt_sink #(.RSP_LATENCY(RSP_LATENCY), .WR_TIMEOUT(WR_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_vld(req_vld), .req_ready(req_ready), .req_cmd(req_cmd),
      .req_address(req_address), .req_len(req_len),
      .req_data(req_data), .req_data_vld(req_data_vld),
      .rsp_ack(rsp_ack), .rsp_nack(rsp_nack),
      .rsp_data(rsp_data), .rsp_data_vld(rsp_data_vld),
      .phy_cr_done(phy_cr_done), .phy_eq_done(phy_eq_done),
      .phy_symbol_lock(phy_symbol_lock), .phy_align_done(phy_align_done),
      .phy_adj_vtg(phy_adj_vtg), .phy_adj_pre(phy_adj_pre),
      .sink_link_bw(sink_link_bw), .sink_lane_cnt(sink_lane_cnt),
      .sink_tps(sink_tps), .sink_lane_set(sink_lane_set),
      .sink_cfg_update(sink_cfg_update)
   );

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endfunction

   function automatic void push(input int kind, input logic [7:0] data, input logic cfg, input int c);
      exp_t e;
      e.kind = kind; e.data = data; e.cfg = cfg; e.cyc = c;
      exp_q.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (rst_n && (rsp_ack || rsp_nack || rsp_data_vld)) begin
         mon_kind = rsp_ack ? K_ACK : (rsp_nack ? K_NACK : K_DATA);
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'(mon_kind), 32'hFFFF_FFFF);
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_kind", 32'(mon_kind), 32'(mon_e.kind));
            check("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
            if (mon_kind == K_DATA) check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
            else                    check("cfg_update", 32'(sink_cfg_update), 32'(mon_e.cfg));
         end
      end
   end

   task automatic send_hdr(input logic [1:0] c, input logic [19:0] a, input logic [7:0] l, output int bc);
      int n = 0;
      while (!req_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      check("req_ready_wait", 32'(req_ready), 32'd1);
      req_vld = 1'b1; req_cmd = c; req_address = a; req_len = l;
      bc = cyc;
      @(posedge clk); #1;
      req_vld = 1'b0;
   endtask

   task automatic do_read(input logic [19:0] a, input logic [7:0] l);
      int bc;
      send_hdr(2'b01, a, l, bc);
      push(K_ACK, 8'h00, 1'b0, bc + RSP_LATENCY);
      for (int i = 0; i < rexp.size(); i++) push(K_DATA, rexp[i], 1'b0, bc + RSP_LATENCY + 1 + i);
   endtask

   task automatic do_write(input logic [19:0] a, input logic [7:0] l, input logic cfg,
                           input int gap, input bit reply, output int last);
      int bc;
      send_hdr(2'b00, a, l, bc);
      last = bc;
      for (int i = 0; i < wbuf.size(); i++) begin
         if (i > 0) repeat (gap) begin @(posedge clk); #1; end
         req_data_vld = 1'b1; req_data = wbuf[i];
         last = cyc;
         @(posedge clk); #1;
         req_data_vld = 1'b0;
      end
      if (reply) push(K_ACK, 8'h00, cfg, last + RSP_LATENCY);
   endtask

   task automatic do_nack(input logic [1:0] c, input logic [19:0] a, input logic [7:0] l);
      int bc;
      send_hdr(c, a, l, bc);
      push(K_NACK, 8'h00, 1'b0, bc + RSP_LATENCY);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk); #1; n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int last, n;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp", 32'({rsp_ack, rsp_nack, rsp_data_vld, sink_cfg_update}), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_sink", {sink_link_bw, 3'b0, sink_lane_cnt, 6'b0, sink_tps, 8'h00}, 32'd0);
      check("rst_lane_set", sink_lane_set, 32'd0);

      // Config write with a two-cycle gap between bytes.
      wbuf = '{8'h0A, 8'h04};
      do_write(20'h00100, 8'd1, 1'b1, 2, 1'b1, last);
      drain();
      check("link_bw", 32'(sink_link_bw), 32'h0A);
      check("lane_cnt_4", 32'(sink_lane_cnt), 32'd4);

      // Two active lanes, status snapshot taken at accept.
      wbuf = '{8'h02};
      do_write(20'h00101, 8'd0, 1'b1, 0, 1'b1, last);
      drain();
      check("lane_cnt_2", 32'(sink_lane_cnt), 32'd2);
      phy_cr_done = 4'hF; phy_eq_done = 4'h3; phy_symbol_lock = 4'h3; phy_align_done = 1'b1;
      rexp = '{8'h77, 8'h00, 8'h01};
      do_read(20'h00202, 8'd2);
      phy_cr_done = 4'h0; phy_eq_done = 4'h0; phy_symbol_lock = 4'h0; phy_align_done = 1'b0;
      drain();

      // Zero lanes masks all status including align.
      wbuf = '{8'h00};
      do_write(20'h00101, 8'd0, 1'b1, 0, 1'b1, last);
      phy_cr_done = 4'hF; phy_eq_done = 4'hF; phy_symbol_lock = 4'hF; phy_align_done = 1'b1;
      rexp = '{8'h00, 8'h00, 8'h00};
      do_read(20'h00202, 8'd2);
      drain();

      // LANE_COUNT_SET keeps [4:0] only; adjust nibbles {pre,vtg}.
      wbuf = '{8'hE4};
      do_write(20'h00101, 8'd0, 1'b1, 0, 1'b1, last);
      drain();
      check("lane_cnt_e4", 32'(sink_lane_cnt), 32'd4);
      phy_adj_vtg = 8'hE4; phy_adj_pre = 8'h1B;
      rexp = '{8'h9C, 8'h36};
      do_read(20'h00206, 8'd1);
      drain();

      wbuf = '{8'h21, 8'h11, 8'h22, 8'h33, 8'h44};
      do_write(20'h00102, 8'd4, 1'b1, 0, 1'b1, last);
      rexp = '{8'h0A, 8'h04, 8'h21, 8'h11, 8'h22, 8'h33, 8'h44};
      do_read(20'h00100, 8'd6);
      drain();
      check("tps", 32'(sink_tps), 32'd1);
      check("lane_set", sink_lane_set, 32'h44332211);

      // NACK cases; data following a NACKed write header is discarded.
      do_nack(2'b10, 20'h00100, 8'd0);
      do_nack(2'b01, 20'h00000, 8'd16);
      do_nack(2'b00, 20'h00100, 8'd16);
      req_data_vld = 1'b1; req_data = 8'hFF;
      repeat (2) begin @(posedge clk); #1; end
      req_data_vld = 1'b0;
      drain();
      check("nack_wr_dropped", 32'(sink_link_bw), 32'h0A);

      // Read-only writes are acknowledged but dropped.
      wbuf = '{8'h55};
      do_write(20'h00000, 8'd0, 1'b0, 0, 1'b1, last);
      rexp = '{8'h12, 8'h14, 8'h04};
      do_read(20'h00000, 8'd2);
      drain();

      // Short write then silence: abort with no reply, early bytes kept.
      wbuf = '{8'hA5, 8'h5A};
      do_write(20'h00103, 8'd3, 1'b0, 0, 1'b0, last);
      repeat (WR_TIMEOUT - 1) begin @(posedge clk); #1; end
      check("timeout_not_yet", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      check("timeout_idle", 32'(req_ready), 32'd1);
      check("timeout_lane_set", sink_lane_set, 32'h44335AA5);

      rexp = '{8'h00, 8'h12};
      do_read(20'hFFFFF, 8'd1);
      drain();

      // Async reset in the middle of a read burst.
      rexp = '{8'h12, 8'h14, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      do_read(20'h00000, 8'd15);
      n = 0;
      while (!rsp_data_vld && n < 50) begin @(posedge clk); #1; n++; end
      check("rd_burst_started", 32'(rsp_data_vld), 32'd1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("rst_mid_vld", 32'(rsp_data_vld), 32'd0);
      check("rst_mid_ready", 32'(req_ready), 32'd1);
      check("rst_mid_sink", {sink_link_bw, 3'b0, sink_lane_cnt, 6'b0, sink_tps, 8'h00}, 32'd0);
      check("rst_mid_lane_set", sink_lane_set, 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      rexp = '{8'h00};
      do_read(20'h00101, 8'd0);
      drain();
      repeat (4) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
